// File: rtl/receptor_ps2_filtrado_pkg.sv
// rtl/receptor_ps2_filtrado_pkg.sv - shared constants and state encodings for the PS/2 receiver
package receptor_ps2_filtrado_pkg;

  localparam logic [7:0] BREAK_CODE     = 8'hF0;
  localparam logic [7:0] EXT_CODE       = 8'hE0;
  localparam int         TIMEOUT_CYCLES = 100_000;
  localparam int         FILTER_LEN     = 8;

  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_DPS  = 2'd1,
    FR_LOAD = 2'd2
  } frame_state_t;

  typedef enum logic {
    FI_ESPERA = 1'b0,
    FI_ROMPE  = 1'b1
  } filt_state_t;

  // bits = {stop, parity, data[7:0]}; valid when data+parity has odd weight and stop is high
  function automatic logic frame_ok(input logic [9:0] bits);
    return (^bits[8:0]) & bits[9];
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 line synchroniser, clock glitch filter and 11-bit frame receiver
module ps2_rx_frame
  import receptor_ps2_filtrado_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  input  logic       rx_en_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_tick_o,
  output logic       error_paridad_o
);

  localparam int TW = $clog2(TIMEOUT);

  logic [1:0]            c_sync_q, d_sync_q;
  logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
  logic                  filt_q, filt_d;
  frame_state_t          state_q, state_d;
  logic [3:0]            n_q, n_d;
  logic [9:0]            b_q, b_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  fall_edge, d_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      c_sync_q  <= '1;
      d_sync_q  <= '1;
      filt_sr_q <= '1;
      filt_q    <= 1'b1;
      state_q   <= FR_IDLE;
      n_q       <= '0;
      b_q       <= '0;
      tmr_q     <= '0;
    end else begin
      c_sync_q  <= {c_sync_q[0], ps2c_i};
      d_sync_q  <= {d_sync_q[0], ps2d_i};
      filt_sr_q <= filt_sr_d;
      filt_q    <= filt_d;
      state_q   <= state_d;
      n_q       <= n_d;
      b_q       <= b_d;
      tmr_q     <= tmr_d;
    end
  end

  // Filtered clock only changes once the whole window agrees, otherwise it holds
  always_comb begin
    filt_sr_d = {c_sync_q[1], filt_sr_q[FILTER_LEN-1:1]};
    filt_d    = filt_q;
    if (&filt_sr_d)       filt_d = 1'b1;
    else if (~|filt_sr_d) filt_d = 1'b0;
  end

  assign fall_edge = filt_q & ~filt_d;
  assign d_s       = d_sync_q[1];

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    b_d     = b_q;
    tmr_d   = tmr_q;
    case (state_q)
      FR_IDLE: begin
        if (fall_edge && rx_en_i && !d_s) begin
          state_d = FR_DPS;
          n_d     = 4'd9;
          tmr_d   = '0;
        end
      end
      FR_DPS: begin
        if (fall_edge) begin
          b_d   = {d_s, b_q[9:1]};
          tmr_d = '0;
          if (n_q == 4'd0) state_d = FR_LOAD;
          else             n_d     = n_q - 4'd1;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d = FR_IDLE;
          n_d     = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      FR_LOAD: state_d = FR_IDLE;
      default: state_d = FR_IDLE;
    endcase
  end

  always_comb begin
    rx_done_tick_o  = 1'b0;
    error_paridad_o = 1'b0;
    if (state_q == FR_LOAD) begin
      if (frame_ok(b_q)) rx_done_tick_o  = 1'b1;
      else               error_paridad_o = 1'b1;
    end
  end

  assign rx_byte_o = b_q[7:0];

endmodule

// File: rtl/receptor_ps2_filtrado.sv
// rtl/receptor_ps2_filtrado.sv - PS/2 keyboard receiver that reports only released (break-code) keys
module receptor_ps2_filtrado
  import receptor_ps2_filtrado_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] Dato_rx,
  output logic       filtro_enable,
  output logic       rx_done_tick,
  output logic       error_paridad
);

  logic [7:0]  rx_byte;
  filt_state_t fst_q, fst_d;
  logic [7:0]  dato_q, dato_d;
  logic        fen_q, fen_d;

  ps2_rx_frame #(.TIMEOUT(TIMEOUT)) u_frame (
    .clk_i           (clk),
    .reset_i         (reset),
    .ps2c_i          (ps2c),
    .ps2d_i          (ps2d),
    .rx_en_i         (rx_en),
    .rx_byte_o       (rx_byte),
    .rx_done_tick_o  (rx_done_tick),
    .error_paridad_o (error_paridad)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fst_q  <= FI_ESPERA;
      dato_q <= 8'h00;
      fen_q  <= 1'b0;
    end else begin
      fst_q  <= fst_d;
      dato_q <= dato_d;
      fen_q  <= fen_d;
    end
  end

  // Extended prefixes and repeated break codes keep ROMPE waiting for the real key
  always_comb begin
    fst_d  = fst_q;
    dato_d = dato_q;
    fen_d  = 1'b0;
    if (error_paridad) begin
      fst_d = FI_ESPERA;
    end else if (rx_done_tick) begin
      case (fst_q)
        FI_ESPERA: if (rx_byte == BREAK_CODE) fst_d = FI_ROMPE;
        FI_ROMPE: begin
          if (rx_byte != EXT_CODE && rx_byte != BREAK_CODE) begin
            dato_d = rx_byte;
            fen_d  = 1'b1;
            fst_d  = FI_ESPERA;
          end
        end
        default: fst_d = FI_ESPERA;
      endcase
    end
  end

  always_comb begin
    Dato_rx       = dato_q;
    filtro_enable = fen_q;
  end

endmodule

// File: tb/tb_receptor_ps2_filtrado.sv
// tb/tb_receptor_ps2_filtrado.sv - randomized self-checking bench for receptor_ps2_filtrado
module tb_receptor_ps2_filtrado;

  localparam int T_SIM = 2000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] Dato_rx;
  logic       filtro_enable, rx_done_tick, error_paridad;

  receptor_ps2_filtrado #(.TIMEOUT(T_SIM)) dut (
    .clk           (clk),
    .reset         (reset),
    .ps2c          (ps2c),
    .ps2d          (ps2d),
    .rx_en         (rx_en),
    .Dato_rx       (Dato_rx),
    .filtro_enable (filtro_enable),
    .rx_done_tick  (rx_done_tick),
    .error_paridad (error_paridad)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         cyc = 0;
  int         n_done = 0, n_err = 0, n_fen = 0, consec = 0;
  int         done_cyc = 0, fen_cyc = 0;
  logic [7:0] fen_data = 8'h00;
  logic       prev_fen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done_tick) begin
      n_done++;
      done_cyc = cyc;
    end
    if (error_paridad) n_err++;
    if (filtro_enable) begin
      n_fen++;
      fen_cyc  = cyc;
      fen_data = Dato_rx;
      if (prev_fen) consec++;
    end
    prev_fen = filtro_enable;
  end

  // Reference: a released key is the first non-prefix byte after a break code
  logic       pend = 1'b0;
  logic [7:0] m_dato = 8'h00;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int half, input bit glitch);
    ps2d = b;
    wait_clk(half);
    if (glitch) begin
      ps2c = 1'b0;
      wait_clk(5);
      ps2c = 1'b1;
      wait_clk(12);
    end
    ps2c = 1'b0;
    wait_clk(half);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input int err_kind, input int en_mode,
                            input int glitch_bit, input int half, input int stall_bit, input int stall);
    logic [10:0] fr;
    fr[0]    = 1'b0;
    fr[8:1]  = data;
    fr[9]    = (~^data) ^ (err_kind == 1);
    fr[10]   = (err_kind != 2);
    if (en_mode == 1) rx_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i == stall_bit) wait_clk(stall);
      drive_bit(fr[i], half, i == glitch_bit);
      if (i == 0 && en_mode == 2) rx_en = 1'b0;
    end
    ps2d = 1'b1;
    wait_clk(half + 20);
    rx_en = 1'b1;
  endtask

  task automatic frame_check(input logic [7:0] data, input int err_kind, input int en_mode,
                             input int glitch_bit, input int half, input int stall_bit, input int stall);
    int d0, e0, f0;
    bit acc, ok, exp_fen;
    d0 = n_done; e0 = n_err; f0 = n_fen;
    send_frame(data, err_kind, en_mode, glitch_bit, half, stall_bit, stall);
    acc     = (en_mode != 1);
    ok      = (err_kind == 0);
    exp_fen = 1'b0;
    if (acc) begin
      if (!ok) pend = 1'b0;
      else if (data == 8'hF0) pend = 1'b1;
      else if (data != 8'hE0 && pend) begin
        m_dato  = data;
        pend    = 1'b0;
        exp_fen = 1'b1;
      end
    end
    chk("done_cnt", n_done - d0, {31'd0, acc && ok});
    chk("err_cnt", n_err - e0, {31'd0, acc && !ok});
    chk("fen_cnt", n_fen - f0, {31'd0, exp_fen});
    chk("dato_rx", {24'd0, Dato_rx}, {24'd0, m_dato});
    if (exp_fen) begin
      chk("fen_latency", fen_cyc - done_cyc, 1);
      chk("fen_data", {24'd0, fen_data}, {24'd0, data});
    end
  endtask

  task automatic quiet_check(input string tag, input int d0, input int e0, input int f0);
    chk({tag, "_done"}, n_done - d0, 0);
    chk({tag, "_err"}, n_err - e0, 0);
    chk({tag, "_fen"}, n_fen - f0, 0);
  endtask

  initial begin
    int d0, e0, f0;
    wait_clk(5);
    chk("rst_dato", {24'd0, Dato_rx}, 0);
    chk("rst_fen", {31'd0, filtro_enable}, 0);
    chk("rst_done", {31'd0, rx_done_tick}, 0);
    chk("rst_err", {31'd0, error_paridad}, 0);
    reset = 1'b0;
    wait_clk(20);

    frame_check(8'h1C, 0, 0, -1, 20, -1, 0);
    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h1C, 0, 0, -1, 20, -1, 0);

    frame_check(8'hE0, 0, 0, -1, 20, -1, 0);
    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h14, 0, 0, -1, 20, -1, 0);

    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h5A, 1, 0, -1, 20, -1, 0);
    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h5A, 0, 0, -1, 20, -1, 0);

    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h33, 2, 0, -1, 20, -1, 0);
    frame_check(8'h33, 0, 0, -1, 20, -1, 0);

    frame_check(8'hF0, 0, 0, 4, 20, -1, 0);
    frame_check(8'h77, 0, 0, 7, 20, -1, 0);

    frame_check(8'hF0, 0, 1, -1, 20, -1, 0);
    frame_check(8'h21, 0, 0, -1, 20, -1, 0);
    frame_check(8'hF0, 0, 2, -1, 20, -1, 0);
    frame_check(8'h21, 0, 0, -1, 20, -1, 0);

    // IDLE glitch with data low must not be taken as a start bit
    d0 = n_done; e0 = n_err; f0 = n_fen;
    ps2d = 1'b0;
    ps2c = 1'b0;
    wait_clk(5);
    ps2c = 1'b1;
    wait_clk(30);
    ps2d = 1'b1;
    wait_clk(10);
    quiet_check("idle_glitch", d0, e0, f0);
    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h45, 0, 0, -1, 20, -1, 0);

    // Gap just below the timeout keeps the frame alive
    frame_check(8'hF0, 0, 0, -1, 20, 5, T_SIM - 300);
    frame_check(8'h4B, 0, 0, -1, 20, 5, T_SIM - 300);

    // Stall after four data bits for 1.05 x timeout
    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    d0 = n_done; e0 = n_err; f0 = n_fen;
    drive_bit(1'b0, 20, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 20, 1'b0);
    ps2d = 1'b1;
    wait_clk(T_SIM + T_SIM / 20);
    quiet_check("timeout", d0, e0, f0);
    frame_check(8'h45, 0, 0, -1, 20, -1, 0);

    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h16, 0, 0, -1, 20, -1, 0);
    drive_bit(1'b0, 20, 1'b0);
    drive_bit(1'b1, 20, 1'b0);
    drive_bit(1'b0, 20, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_dato", {24'd0, Dato_rx}, 0);
    chk("mid_rst_fen", {31'd0, filtro_enable}, 0);
    chk("mid_rst_done", {31'd0, rx_done_tick}, 0);
    chk("mid_rst_err", {31'd0, error_paridad}, 0);
    m_dato = 8'h00;
    pend   = 1'b0;
    ps2c   = 1'b1;
    ps2d   = 1'b1;
    wait_clk(4);
    reset = 1'b0;
    wait_clk(20);
    frame_check(8'hF0, 0, 0, -1, 20, -1, 0);
    frame_check(8'h29, 0, 0, -1, 20, -1, 0);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] data;
      int sel, ek, em, gb, hf;
      sel  = $urandom_range(0, 9);
      data = (sel < 3) ? 8'hF0 : (sel == 3) ? 8'hE0 : 8'($urandom_range(0, 255));
      ek   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
      sel  = $urandom_range(0, 9);
      em   = (sel == 0) ? 1 : (sel == 1) ? 2 : 0;
      gb   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 10) : -1;
      hf   = $urandom_range(15, 30);
      frame_check(data, ek, em, gb, hf, -1, 0);
    end

    chk("no_consec_fen", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
